// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: FSM state type and round-robin pick helper shared by the arbiter
package mux_arb_pkg;
  localparam int MAX_N = 64;
  localparam int IW = 6;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
  } pick_t;
  // First set bit of r[n-1:0] searching ptr+1, ptr+2, ... modulo n, so the index is always < n.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] r, input int ptr, input int n);
    pick_t p;
    logic [IW-1:0] j;
    p = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      j = IW'((ptr + k) % n);
      if (!p.found && k <= n && r[j]) begin
        p.found = 1'b1;
        p.idx = j;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/mux_nto1.sv
// mux_nto1: one-bit N-to-1 mux, Y = I[S]
//   I  in  N          candidate bits
//   S  in  $clog2(N)  select (always < N)
//   Y  out 1          selected bit
module mux_nto1 #(
  parameter int N = 8
) (
  input  logic [N-1:0]         I,
  input  logic [$clog2(N)-1:0] S,
  output logic                 Y
);
  assign Y = I[S];
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one N-to-1 data mux over a valid/ready port
//   clk, rst_n      clock, asynchronous active-low reset
//   req, din        per-requester request and W-bit data slice (slice i = din[i*W +: W])
//   gnt             one-hot pulse on the served requester's handshake cycle
//   sel, dout       registered select and the selected data word
//   dout_valid/ready output handshake
//   lock            only with MUX_ARB_LOCK_EN: holds the grant across a handshake (bursts)
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic [W-1:0]         dout,
  output logic                 dout_valid,
  input  logic                 dout_ready
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic                 lock
`endif
);
  localparam int SW = $clog2(N);
  arb_state_t state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, ptr_q, ptr_d;
  logic [MAX_N-1:0] cand;
  logic hs, lock_w;
  pick_t pk;
`ifdef MUX_ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif
  assign hs = state_q == GRANT && dout_ready;
  assign gnt = hs ? N'(1) << sel_q : '0;
  assign dout_valid = state_q == GRANT;
  assign sel = sel_q;
  // On a handshake the served requester's req is stale, so it is masked and the search starts after it.
  always_comb begin
    cand = '0;
    cand[N-1:0] = hs ? req & ~gnt : req;
    pk = rr_pick(cand, int'(hs ? sel_q : ptr_q), N);
    state_d = state_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (state_q == IDLE) begin
      state_d = pk.found ? GRANT : IDLE;
      sel_d = pk.found ? SW'(pk.idx) : sel_q;
    end else if (hs && !lock_w) begin
      ptr_d = sel_q;
      state_d = pk.found ? GRANT : IDLE;
      sel_d = pk.found ? SW'(pk.idx) : sel_q;
    end else if (!hs && !req[sel_q]) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      ptr_q <= SW'(N - 1);
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end
  for (genvar b = 0; b < W; b++) begin : g_bit
    logic [N-1:0] col;
    for (genvar i = 0; i < N; i++) begin : g_col
      assign col[i] = din[i*W+b];
    end
    mux_nto1 #(.N(N)) u_mux (.I(col), .S(sel_q), .Y(dout[b]));
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios plus randomized traffic against a set-based round-robin model
module tb_mux_rr_arbiter;
  localparam int N = 8;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0] gnt;
  logic [2:0] sel;
  logic [W-1:0] dout;
  logic dout_valid;
  logic dout_ready = 1'b0;
  logic lock = 1'b0;
  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .gnt(gnt), .sel(sel),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
`ifdef MUX_ARB_LOCK_EN
    , .lock(lock)
`endif
  );

  // Round-robin rule: first requester in s after 'last', wrapping; -1 if none.
  function automatic int first_after(logic [N-1:0] s, int last);
    for (int k = 1; k <= N; k++)
      if (s[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] slice(int i);
    return din[i*W +: W];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    dout_ready = 1'b0;
    lock = 1'b0;
    din = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'hFF;
    dout_ready = 1'b1;
    din = {$urandom, $urandom};
    @(negedge clk);
    #1;
    n_checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", dout_valid); else n_pass++;
    n_checks++; if (sel !== 3'd0) $display("FAIL reset_sel got %0d exp 0", sel); else n_pass++;
    n_checks++; if (gnt !== 8'h00) $display("FAIL reset_gnt got %h exp 00", gnt); else n_pass++;
    n_checks++; if (dout !== din[7:0]) $display("FAIL reset_dout got %h exp %h", dout, din[7:0]); else n_pass++;
    @(negedge clk);
    req = '0;
    dout_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 8'h01;
    din[7:0] = 8'hA5;
    dout_ready = 1'b1;
    #1;
    n_checks++; if (dout_valid !== 1'b0) $display("FAIL single_latency got %b exp 0", dout_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (dout_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", dout_valid); else n_pass++;
    n_checks++; if (sel !== 3'd0) $display("FAIL single_sel got %0d exp 0", sel); else n_pass++;
    n_checks++; if (dout !== 8'hA5) $display("FAIL single_dout got %h exp a5", dout); else n_pass++;
    n_checks++; if (gnt !== 8'h01) $display("FAIL single_gnt got %h exp 01", gnt); else n_pass++;
    @(negedge clk);
    req = '0;
    #1;
    n_checks++; if (dout_valid !== 1'b0) $display("FAIL single_idle got %b exp 0", dout_valid); else n_pass++;
    n_checks++; if (gnt !== 8'h00) $display("FAIL single_gnt_idle got %h exp 00", gnt); else n_pass++;
  endtask

  task automatic test_rotation();
    int prev = -1;
    int prev2 = -1;
    int exp = 0;
    int cnt[N];
    int bad = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    do_reset();
    @(negedge clk);
    req = 8'hFF;
    dout_ready = 1'b1;
    for (int it = 0; it < 9; it++) begin
      @(negedge clk);
      if (prev2 >= 0) req[prev2] = 1'b1;
      if (prev >= 0) req[prev] = 1'b0;
      #1;
      n_checks++; if (dout_valid !== 1'b1) $display("FAIL rot_valid it=%0d got %b exp 1", it, dout_valid); else n_pass++;
      n_checks++; if (gnt !== N'(1) << exp) $display("FAIL rot_gnt it=%0d got %h exp %h", it, gnt, N'(1) << exp); else n_pass++;
      n_checks++; if (dout !== slice(exp)) $display("FAIL rot_dout it=%0d got %h exp %h", it, dout, slice(exp)); else n_pass++;
      if (it < N)
        for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
      prev2 = prev;
      prev = exp;
      exp = (exp + 1) % N;
    end
    for (int i = 0; i < N; i++) if (cnt[i] != 1) bad++;
    n_checks++; if (bad != 0) $display("FAIL rot_fair got %0d requesters not granted once exp 0", bad); else n_pass++;
    @(negedge clk);
    req = '0;
    dout_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    req = 8'h90;
    dout_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_checks++; if (sel !== 3'd4 || dout_valid !== 1'b1) $display("FAIL wrap_hold c=%0d got sel %0d valid %b exp sel 4 valid 1", c, sel, dout_valid); else n_pass++;
      n_checks++; if (dout !== slice(4)) $display("FAIL wrap_dout c=%0d got %h exp %h", c, dout, slice(4)); else n_pass++;
      n_checks++; if (gnt !== 8'h00) $display("FAIL wrap_nognt c=%0d got %h exp 00", c, gnt); else n_pass++;
    end
    @(negedge clk);
    dout_ready = 1'b1;
    #1;
    n_checks++; if (gnt !== 8'h10) $display("FAIL wrap_gnt4 got %h exp 10", gnt); else n_pass++;
    @(negedge clk);
    req = 8'h81;
    #1;
    n_checks++; if (sel !== 3'd7 || gnt !== 8'h80) $display("FAIL wrap_sel7 got sel %0d gnt %h exp sel 7 gnt 80", sel, gnt); else n_pass++;
    @(negedge clk);
    req = 8'h01;
    #1;
    n_checks++; if (sel !== 3'd0 || gnt !== 8'h01) $display("FAIL wrap_sel0 got sel %0d gnt %h exp sel 0 gnt 01", sel, gnt); else n_pass++;
    @(negedge clk);
    req = '0;
    dout_ready = 1'b0;
  endtask

  task automatic test_abandon();
    int exp;
    do_reset();
    @(negedge clk);
    req = 8'h02;
    dout_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (gnt !== 8'h02) $display("FAIL ab_first_gnt got %h exp 02", gnt); else n_pass++;
    @(negedge clk);
    req = 8'h08;
    dout_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (sel !== 3'd3 || dout_valid !== 1'b1) $display("FAIL ab_sel3 got sel %0d valid %b exp sel 3 valid 1", sel, dout_valid); else n_pass++;
    @(negedge clk);
    req = '0;
    #1;
    n_checks++; if (gnt !== 8'h00) $display("FAIL ab_withdraw_gnt got %h exp 00", gnt); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (dout_valid !== 1'b0 || gnt !== 8'h00) $display("FAIL ab_idle got valid %b gnt %h exp valid 0 gnt 00", dout_valid, gnt); else n_pass++;
    req = 8'h0A;
    exp = first_after(8'h0A, 1);
    @(negedge clk);
    #1;
    n_checks++; if (sel !== 3'(exp) || dout_valid !== 1'b1) $display("FAIL ab_regrant got sel %0d valid %b exp sel %0d valid 1", sel, dout_valid, exp); else n_pass++;
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req = 8'h20;
    dout_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (sel !== 3'd5 || dout_valid !== 1'b1) $display("FAIL rm_pre got sel %0d valid %b exp sel 5 valid 1", sel, dout_valid); else n_pass++;
    #2;
    rst_n = 1'b0;
    dout_ready = 1'b1;
    #1;
    n_checks++; if (dout_valid !== 1'b0) $display("FAIL rm_valid got %b exp 0", dout_valid); else n_pass++;
    n_checks++; if (sel !== 3'd0) $display("FAIL rm_sel got %0d exp 0", sel); else n_pass++;
    n_checks++; if (gnt !== 8'h00) $display("FAIL rm_gnt got %h exp 00", gnt); else n_pass++;
    @(negedge clk);
    req = 8'hFF;
    dout_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (sel !== 3'd0 || dout_valid !== 1'b1) $display("FAIL rm_after got sel %0d valid %b exp sel 0 valid 1", sel, dout_valid); else n_pass++;
    req = '0;
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    @(negedge clk);
    req = 8'h06;
    dout_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      lock = b < 3;
      #1;
      n_checks++; if (gnt !== 8'h02) $display("FAIL lock_beat%0d got %h exp 02", b, gnt); else n_pass++;
    end
    @(negedge clk);
    req = 8'h04;
    lock = 1'b0;
    #1;
    n_checks++; if (gnt !== 8'h04) $display("FAIL lock_next got %h exp 04", gnt); else n_pass++;
    @(negedge clk);
    req = '0;
    dout_ready = 1'b0;
  endtask
`endif

  // Model state: whether a word is on offer, whose it is, and who was served last.
  task automatic test_random();
    bit m_valid = 1'b0;
    int m_sel = 0;
    int m_last = N - 1;
    int served = -1;
    int nxt;
    logic [N-1:0] exp_gnt;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (served >= 0) req[served] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!req[i] && i != served && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
          din[i*W +: W] = W'($urandom);
        end
      dout_ready = $urandom_range(3) != 0;
      #1;
      exp_gnt = (m_valid && dout_ready) ? N'(1) << m_sel : '0;
      n_checks++; if (dout_valid !== m_valid) $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, dout_valid, m_valid); else n_pass++;
      n_checks++; if (gnt !== exp_gnt) $display("FAIL rnd_gnt cyc=%0d got %h exp %h", cyc, gnt, exp_gnt); else n_pass++;
      if (m_valid) begin
        n_checks++; if (sel !== 3'(m_sel) || dout !== slice(m_sel)) $display("FAIL rnd_data cyc=%0d got sel %0d dout %h exp sel %0d dout %h", cyc, sel, dout, m_sel, slice(m_sel)); else n_pass++;
      end
      served = -1;
      if (m_valid && dout_ready) begin
        served = m_sel;
        m_last = m_sel;
        nxt = first_after(req & ~(N'(1) << m_sel), m_last);
      end else if (m_valid) begin
        nxt = m_sel;
      end else begin
        nxt = first_after(req, m_last);
      end
      m_valid = nxt >= 0;
      if (nxt >= 0) m_sel = nxt;
    end
    @(negedge clk);
    req = '0;
    dout_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_abandon();
    test_reset_mid();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
